// File: rtl/mips_fetch_pkg.sv
// Shared constants, opcode encodings and state type for the instruction fetch path.
// Program base addresses index the three resident programs in instruction memory.
package mips_fetch_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_JUMP = 6'b010000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LD   = 6'b100010;
    localparam logic [5:0] OP_LDI  = 6'b100011;
    localparam logic [5:0] OP_ST   = 6'b101010;

    localparam logic [ADDR_W-1:0] PROG0_BASE = 10'd0;
    localparam logic [ADDR_W-1:0] PROG1_BASE = 10'd15;
    localparam logic [ADDR_W-1:0] PROG2_BASE = 10'd24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Selector 3 is unused by software and falls back to program 0.
    function automatic logic [ADDR_W-1:0] prog_base(input logic [1:0] sel);
        case (sel)
            2'd1:    prog_base = PROG1_BASE;
            2'd2:    prog_base = PROG2_BASE;
            default: prog_base = PROG0_BASE;
        endcase
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational fetch priority mux: chooses the memory address for this cycle and
// the next values of the sequential pc, the tagged instruction address and valid.
module fetch_next_pc
    import mips_fetch_pkg::*;
(
    input  state_t            state_i,
    input  logic              start_i,
    input  logic [1:0]        prog_sel_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              halt_req_i,
    input  logic [5:0]        opcode_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] instr_pc_i,
    input  logic              valid_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              valid_o,
    output logic              is_jump_o
);

    logic              redirect;
    logic [ADDR_W-1:0] target;

    always_comb begin
        is_jump_o   = valid_i && (opcode_i == OP_JUMP);
        redirect    = 1'b0;
        target      = '0;
        imem_addr_o = '0;
        pc_o        = pc_i;
        instr_pc_o  = instr_pc_i;
        valid_o     = valid_i;

        if (state_i == ST_FETCH) begin
            if (halt_req_i) begin
                valid_o = 1'b0;
            end else if (branch_taken_i) begin
                redirect = 1'b1;
                target   = branch_target_i;
            end else if (stall_i) begin
                // Re-read the word decode is holding so it is still on imem_data next cycle.
                imem_addr_o = instr_pc_i;
            end else if (is_jump_o) begin
                redirect = 1'b1;
                target   = jump_target_i;
            end else begin
                imem_addr_o = pc_i;
                instr_pc_o  = pc_i;
                pc_o        = pc_i + ADDR_W'(1);
                valid_o     = 1'b1;
            end
        end else begin
            valid_o = 1'b0;
            if (start_i) begin
                redirect = 1'b1;
                target   = prog_base(prog_sel_i);
            end
        end

        if (redirect) begin
            imem_addr_o = target;
            instr_pc_o  = target;
            pc_o        = target + ADDR_W'(1);
            valid_o     = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer in front of a one-cycle synchronous instruction memory: holds the
// pc/state registers and tags each returned word with its address and validity.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        prog_sel,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              busy
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              is_jump;

    fetch_next_pc u_next (
        .state_i         (state_q),
        .start_i         (start),
        .prog_sel_i      (prog_sel),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .halt_req_i      (halt_req),
        .opcode_i        (imem_data[31:26]),
        .jump_target_i   (imem_data[ADDR_W-1:0]),
        .pc_i            (pc_q),
        .instr_pc_i      (instr_pc_q),
        .valid_i         (valid_q),
        .imem_addr_o     (imem_addr),
        .pc_o            (pc_d),
        .instr_pc_o      (instr_pc_d),
        .valid_o         (valid_d),
        .is_jump_o       (is_jump)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            case (state_q)
                ST_FETCH: if (halt_req) state_q <= ST_HALT;
                ST_IDLE,
                ST_HALT:  if (start) state_q <= ST_FETCH;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Branch-shadow words and locally consumed jumps never reach decode.
    assign busy        = (state_q == ST_FETCH);
    assign instr       = imem_data;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q && busy && !branch_taken && !is_jump;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a memory model and an
// address-stream reference model of the fetch rules.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = 10'd0;
    logic        halt_req = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        busy;

    logic [31:0] mem [0:1023];

    int total = 0;
    int bad = 0;

    // Reference model: running flag, address of word on the bus, next sequential address, live flag.
    bit         m_run, m_live, m_run_n, m_live_n;
    logic [9:0] m_cur, m_nxt, m_cur_n, m_nxt_n;

    instruction_fetch_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .prog_sel      (prog_sel),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd1:    return 10'd15;
            2'd2:    return 10'd24;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b010000) w[31] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        m_run = 0; m_live = 0; m_cur = 10'd0; m_nxt = 10'd0;
    endtask

    // Apply inputs, then at the falling edge compare against the model and stage its next state.
    task automatic drive(input bit st, input logic [1:0] sel, input bit sl,
                         input bit bt, input logic [9:0] tgt, input bit hr);
        logic [9:0]  ea;
        logic [31:0] w;
        bit          ev, jmp;
        start = st; prog_sel = sel; stall = sl;
        branch_taken = bt; branch_target = tgt; halt_req = hr;
        @(negedge clock);
        w   = mem[m_cur];
        jmp = m_run && m_live && (w[31:26] == 6'b010000);
        m_run_n = m_run; m_live_n = m_live; m_cur_n = m_cur; m_nxt_n = m_nxt;
        ea = 10'd0;
        ev = 0;
        if (!m_run) begin
            if (st) begin
                ea = base_of(sel);
                m_run_n = 1; m_live_n = 1; m_cur_n = ea; m_nxt_n = ea + 10'd1;
            end
        end else begin
            ev = m_live && !bt && !jmp;
            if (hr) begin
                m_run_n = 0; m_live_n = 0;
            end else if (bt) begin
                ea = tgt; m_cur_n = tgt; m_nxt_n = tgt + 10'd1; m_live_n = 1;
            end else if (sl) begin
                ea = m_cur;
            end else if (jmp) begin
                ea = w[9:0]; m_cur_n = w[9:0]; m_nxt_n = w[9:0] + 10'd1; m_live_n = 1;
            end else begin
                ea = m_nxt; m_cur_n = m_nxt; m_nxt_n = m_nxt + 10'd1; m_live_n = 1;
            end
        end
        check("m_addr", imem_addr, ea);
        check("m_valid", instr_valid, ev);
        check("m_busy", busy, m_run);
        check("m_pc", instr_pc, m_cur);
        if (ev) check("m_instr", instr, w);
    endtask

    task automatic adv();
        @(posedge clock);
        m_run = m_run_n; m_live = m_live_n; m_cur = m_cur_n; m_nxt = m_nxt_n;
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 2'd0, 0, 0, 10'd0, 0);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = plain_word();
        for (int k = 0; k < 24; k++)
            mem[$urandom_range(100, 900)] = {6'b010000, 16'($urandom), 10'($urandom)};
        mem[9] = {6'b010000, 16'd0, 10'd6};
        model_reset();

        // Reset state
        #12;
        check("rst_addr", imem_addr, 10'd0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pc", instr_pc, 10'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Start program 0 and fetch sequentially
        drive(1, 2'd0, 0, 0, 10'd0, 0);
        check("t1_start_addr", imem_addr, 10'd0);
        adv();
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("t1_pc", instr_pc, 10'(i));
            check("t1_instr", instr, mem[i]);
            check("t1_busy", busy, 1'b1);
            adv();
        end

        // Stall three cycles on address 3
        for (int k = 0; k < 3; k++) begin
            drive(0, 2'd0, 1, 0, 10'd0, 0);
            check("t4_stall_pc", instr_pc, 10'd3);
            check("t4_stall_addr", imem_addr, 10'd3);
            check("t4_stall_valid", instr_valid, 1'b1);
            check("t4_stall_instr", instr, mem[3]);
            adv();
        end
        idle_cycle();
        check("t4_release_addr", imem_addr, 10'd4);
        adv();
        idle_cycle();
        check("t4_after_pc", instr_pc, 10'd4);
        adv();
        for (int i = 5; i < 9; i++) begin
            idle_cycle();
            check("t2_pc", instr_pc, 10'(i));
            adv();
        end

        // Local jump at 9 back to 6
        idle_cycle();
        check("t2_jump_pc", instr_pc, 10'd9);
        check("t2_jump_valid", instr_valid, 1'b0);
        check("t2_jump_addr", imem_addr, 10'd6);
        adv();
        idle_cycle();
        check("t2_target_pc", instr_pc, 10'd6);
        check("t2_target_valid", instr_valid, 1'b1);
        adv();

        // Branch redirect from 7 to 21
        drive(0, 2'd0, 0, 1, 10'd21, 0);
        check("t3_pc", instr_pc, 10'd7);
        check("t3_valid", instr_valid, 1'b0);
        check("t3_addr", imem_addr, 10'd21);
        adv();
        idle_cycle();
        check("t3_target_pc", instr_pc, 10'd21);
        check("t3_target_valid", instr_valid, 1'b1);
        adv();

        // Halt, restart programs 1 and 3->0
        drive(0, 2'd0, 0, 0, 10'd0, 1);
        adv();
        idle_cycle();
        check("t5_busy", busy, 1'b0);
        check("t5_valid", instr_valid, 1'b0);
        check("t5_addr", imem_addr, 10'd0);
        adv();
        drive(1, 2'd1, 0, 0, 10'd0, 0);
        check("t5_p1_addr", imem_addr, 10'd15);
        adv();
        idle_cycle();
        check("t5_p1_pc", instr_pc, 10'd15);
        adv();
        drive(0, 2'd0, 0, 0, 10'd0, 1);
        adv();
        drive(1, 2'd3, 0, 0, 10'd0, 0);
        check("t5_p3_addr", imem_addr, 10'd0);
        adv();
        idle_cycle();
        check("t5_p3_pc", instr_pc, 10'd0);
        adv();

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, 10'($urandom), $urandom_range(0, 24) == 0);
            adv();
        end

        // Address wrap, then asynchronous reset mid-cycle
        drive(0, 2'd0, 0, 0, 10'd0, 1);
        adv();
        drive(1, 2'd2, 0, 0, 10'd0, 0);
        adv();
        mem[1022] = plain_word();
        mem[1023] = plain_word();
        drive(0, 2'd0, 0, 1, 10'd1022, 0);
        adv();
        idle_cycle();
        check("t6_pc_1022", instr_pc, 10'd1022);
        adv();
        idle_cycle();
        check("t6_pc_1023", instr_pc, 10'd1023);
        adv();
        idle_cycle();
        check("t6_pc_wrap", instr_pc, 10'd0);
        check("t6_wrap_valid", instr_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_addr", imem_addr, 10'd0);
        check("t6_rst_valid", instr_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_pc", instr_pc, 10'd0);
        model_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle_cycle();
            check("t6_idle_busy", busy, 1'b0);
            adv();
        end
        drive(1, 2'd1, 0, 0, 10'd0, 0);
        adv();
        idle_cycle();
        check("t6_resume_pc", instr_pc, 10'd15);
        check("t6_resume_busy", busy, 1'b1);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
